bin_to_dec_display: RTL and testbench
=====================================

Name: bin_to_dec_display

Overview:
- Sequential, parametrised binary-to-decimal 7-segment driver for the score and credit displays.
- Accepts an unsigned binary value through a valid/ready handshake and converts it to BCD iteratively (shift-add-3, one bit per clock).
- Drives DIGITS active-low 7-segment digits, with optional leading-zero blanking and an overflow indication.
- Displayed digits hold their last value until a new conversion completes.

Parameters:
- IN_WIDTH, 8, width of the binary input; legal range 1..20.
- DIGITS, 3, number of decimal digits driven; legal range 1..6.
- BLANK_LZ, 1, when 1 leading zero digits are blanked; when 0 all digits are always shown.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- resetn  input  1  synchronous active-low reset; sampled on the clk rising edge.
- in_value  input  IN_WIDTH  unsigned binary value to display.
- in_valid  input  1  in_value is valid this cycle.
- in_ready  output  1  block is idle and can accept a value.
- seg  output  7*DIGITS  segment codes, active-low, per digit ordered {g,f,e,d,c,b,a}; seg[6:0] is the least significant digit.
- done  output  1  one-cycle pulse on the cycle in which seg updates.
- overflow  output  1  last accepted value exceeded 10^DIGITS-1; held until the next update.

Behaviour:
- Reset (resetn=0 at an edge):
  - State goes to IDLE; in_ready=1, done=0, overflow=0.
  - seg[6:0] shows "0" (1000000).
  - Higher digits show blank (1111111) if BLANK_LZ=1, otherwise "0".
  - Reset takes priority over every other event.
- Digit codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000.
  - blank=1111111, dash=0111111.
- States: IDLE, SHIFT, UPDATE.
  - IDLE: in_ready=1. If in_valid=1 at an edge:
    - capture in_value into the shift register;
    - clear the BCD register (4*DIGITS bits, plus carry-out detection);
    - load bit counter = IN_WIDTH;
    - go to SHIFT.
  - IDLE with in_valid=0: no change.
  - SHIFT: in_ready=0. Each edge:
    - add 3 to every BCD nibble that is >=5;
    - shift {BCD, binary} left by one;
    - decrement the counter.
    After IN_WIDTH SHIFT edges, go to UPDATE.
  - UPDATE: one cycle. At its edge:
    - register seg and overflow;
    - assert done for exactly the following cycle;
    - return to IDLE.
- Latency: value accepted at edge k; seg, overflow and done are valid after edge k+IN_WIDTH+1. in_ready returns to 1 in that same cycle.
- Overflow: the captured value is compared against the localparam 10^DIGITS-1 at accept time. If greater, at UPDATE all digits show dash and overflow=1. Otherwise overflow=0 and the digits are decoded normally.
- Blanking (BLANK_LZ=1):
  - A digit is blanked iff it and every more-significant digit are zero.
  - Digit 0 is never blanked.
  - Internal zeros are shown.
- Conversion inputs:
  - in_value and in_valid are ignored outside IDLE; there is no queue and no value is dropped silently.
  - in_value changes after acceptance do not affect the result.
- Back-to-back: in_valid held high in IDLE starts the next conversion at the first IDLE edge. Throughput is one value per IN_WIDTH+2 cycles.
- Reset mid-SHIFT or mid-UPDATE: the conversion is aborted, no done pulse is produced, and outputs take their reset values.
- Arithmetic: the BCD nibbles never exceed 9 after add-3 correction. Bits shifted beyond DIGITS nibbles are discarded; overflow is already flagged by the compare.

Test Plan:
- Defaults: reset, then in_value=21 with in_valid pulsed at edge k -> done pulse and seg = {blank, 0100100, 1111001} after edge k+9; overflow=0; in_ready=0 for cycles k+1..k+8.
- Defaults: in_value=0 -> seg = {1111111, 1111111, 1000000}; in_value=100 -> seg = {1111001, 1000000, 1000000} (internal zeros shown); in_value=255 -> {0100100, 0010010, 0010010}.
- DIGITS=2, IN_WIDTH=8, in_value=99 -> "99", overflow=0; then in_value=100 -> seg = {0111111, 0111111}, overflow=1; then in_value=5 -> overflow returns to 0, seg = {blank, 0010010}.
- BLANK_LZ=0, DIGITS=3, in_value=7 -> seg = {1000000, 1000000, 1111000}; after reset all three digits show 1000000.
- Defaults: accept 42, then assert resetn=0 at edge k+4 -> no done pulse; seg returns to the reset pattern; in_ready=1 after the reset edge; a new value 13 then converts correctly.
- Defaults: in_valid held high with in_value changing each cycle (30, 31, 32, ...) -> only values sampled in IDLE cycles are displayed; consecutive done pulses are exactly 10 cycles apart; in_value changes during SHIFT do not affect the result.

Source files
------------

// File: rtl/bin_to_dec_display.sv
// Iterative binary-to-BCD converter (shift-add-3, one bit per clock) driving
// active-low 7-segment digits with optional leading-zero blanking and overflow dash.
module bin_to_dec_display #(
  parameter int IN_WIDTH = 8,
  parameter int DIGITS   = 3,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [IN_WIDTH-1:0]   in_value,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  done,
  output logic                  overflow
);

  localparam int              BW        = 4 * DIGITS;
  localparam int              CW        = $clog2(IN_WIDTH + 1);
  localparam logic [31:0]     MAX_VAL   = 32'(10 ** DIGITS - 1);
  localparam logic [CW-1:0]   CNT_LOAD  = CW'(IN_WIDTH);
  localparam logic [6:0]      SEG_BLANK = 7'b1111111;
  localparam logic [6:0]      SEG_DASH  = 7'b0111111;
  localparam logic [6:0]      SEG_ZERO  = 7'b1000000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IN_WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [BW-1:0]       adj_s;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ovf_pend_q, ovf_pend_d;
  logic [7*DIGITS-1:0] seg_q, seg_d, seg_rst_s, seg_dec_s;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic                ready_q, ready_d;
  logic                lead_s;

  function automatic logic [6:0] digit_code(input logic [3:0] nib);
    case (nib)
      4'd0:    digit_code = 7'b1000000;
      4'd1:    digit_code = 7'b1111001;
      4'd2:    digit_code = 7'b0100100;
      4'd3:    digit_code = 7'b0110000;
      4'd4:    digit_code = 7'b0011001;
      4'd5:    digit_code = 7'b0010010;
      4'd6:    digit_code = 7'b0000010;
      4'd7:    digit_code = 7'b1111000;
      4'd8:    digit_code = 7'b0000000;
      4'd9:    digit_code = 7'b0011000;
      default: digit_code = SEG_BLANK;
    endcase
  endfunction

  function automatic logic [BW-1:0] add3(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Reset pattern: "0" on digit 0, higher digits blank or "0"
  always_comb begin
    seg_rst_s = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (i == 0 || !BLANK_LZ) begin
        seg_rst_s[7*i +: 7] = SEG_ZERO;
      end else begin
        seg_rst_s[7*i +: 7] = SEG_BLANK;
      end
    end
  end

  // Digit decode; lead_s tracks a run of zeros from the most significant digit down
  always_comb begin
    seg_dec_s = '1;
    lead_s    = BLANK_LZ;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (ovf_pend_q) begin
        seg_dec_s[7*i +: 7] = SEG_DASH;
      end else if (lead_s && (i != 0) && (bcd_q[4*i +: 4] == 4'd0)) begin
        seg_dec_s[7*i +: 7] = SEG_BLANK;
      end else begin
        seg_dec_s[7*i +: 7] = digit_code(bcd_q[4*i +: 4]);
        lead_s              = 1'b0;
      end
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    seg_d      = seg_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    adj_s      = add3(bcd_q);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d    = SHIFT;
          bin_d      = in_value;
          bcd_d      = '0;
          cnt_d      = CNT_LOAD;
          ovf_pend_d = (32'(in_value) > MAX_VAL);
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // Bits pushed past the top nibble are dropped; the accept-time compare covers them
        bcd_d = BW'({adj_s, bin_q[IN_WIDTH-1]});
        bin_d = bin_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = UPDATE;
        end else begin
          state_d = SHIFT;
        end
      end
      UPDATE: begin
        seg_d   = seg_dec_s;
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      seg_q      <= seg_rst_s;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      seg_q      <= seg_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      ready_q    <= ready_d;
    end
  end

  assign in_ready = ready_q;
  assign seg      = seg_q;
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_dec_display.sv
// Bench for bin_to_dec_display: three instances (defaults, DIGITS=2, BLANK_LZ=0)
// share stimulus; results are checked against a table and an arithmetic model.
module tb_bin_to_dec_display;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic [7:0]  in_value;

  logic        rdy1, done1, ovf1;
  logic [20:0] seg1;
  logic        rdy2, done2, ovf2;
  logic [13:0] seg2;
  logic        rdy3, done3, ovf3;
  logic [20:0] seg3;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] CODES [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                        7'b0000000, 7'b0011000};

  always #5 clk = ~clk;

  bin_to_dec_display #(.IN_WIDTH(8), .DIGITS(3), .BLANK_LZ(1'b1)) dut1 (
    .clk(clk), .resetn(resetn), .in_value(in_value), .in_valid(in_valid),
    .in_ready(rdy1), .seg(seg1), .done(done1), .overflow(ovf1));

  bin_to_dec_display #(.IN_WIDTH(8), .DIGITS(2), .BLANK_LZ(1'b1)) dut2 (
    .clk(clk), .resetn(resetn), .in_value(in_value), .in_valid(in_valid),
    .in_ready(rdy2), .seg(seg2), .done(done2), .overflow(ovf2));

  bin_to_dec_display #(.IN_WIDTH(8), .DIGITS(3), .BLANK_LZ(1'b0)) dut3 (
    .clk(clk), .resetn(resetn), .in_value(in_value), .in_valid(in_valid),
    .in_ready(rdy3), .seg(seg3), .done(done3), .overflow(ovf3));

  typedef struct {
    logic [7:0]  val;
    logic [20:0] exp_seg3;
    logic [13:0] exp_seg2;
    logic        exp_ovf2;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Display pattern from decimal arithmetic on the value
  function automatic logic [41:0] model_seg(input int v, input int nd, input bit blz);
    logic [41:0] r;
    int p;
    int pw;
    r = {42{1'b1}};
    p = 1;
    for (int i = 0; i < nd; i++) p = p * 10;
    for (int i = 0; i < nd; i++) begin
      pw = 1;
      for (int j = 0; j < i; j++) pw = pw * 10;
      if (v > p - 1)                   r[7*i +: 7] = DASH;
      else if (blz && i != 0 && v < pw) r[7*i +: 7] = BLANK;
      else                             r[7*i +: 7] = CODES[(v / pw) % 10];
    end
    return r;
  endfunction

  task automatic check_all(input int v);
    logic [41:0] m;
    m = model_seg(v, 3, 1'b1);
    chk("seg_d3", seg1, m[20:0]);
    chk("ovf_d3", ovf1, (v > 999));
    m = model_seg(v, 2, 1'b1);
    chk("seg_d2", seg2, m[13:0]);
    chk("ovf_d2", ovf2, (v > 99));
    m = model_seg(v, 3, 1'b0);
    chk("seg_nolz", seg3, m[20:0]);
    chk("ovf_nolz", ovf3, (v > 999));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_seg_d3"}, seg1, {BLANK, BLANK, CODES[0]});
    chk({tag, "_seg_d2"}, seg2, {BLANK, CODES[0]});
    chk({tag, "_seg_nolz"}, seg3, {CODES[0], CODES[0], CODES[0]});
    chk({tag, "_ready"}, {rdy1, rdy2, rdy3}, 3'b111);
    chk({tag, "_done"}, {done1, done2, done3}, 3'b000);
    chk({tag, "_ovf"}, {ovf1, ovf2, ovf3}, 3'b000);
  endtask

  // One conversion from IDLE; inputs are scrambled while busy
  task automatic convert(input logic [7:0] v);
    int edges;
    bit busy_ok;
    chk("ready_before", rdy1, 1'b1);
    in_value = v;
    in_valid = 1'b1;
    @(negedge clk);
    edges   = 0;
    busy_ok = 1'b1;
    while (done1 !== 1'b1 && edges < 20) begin
      if (rdy1 !== 1'b0) busy_ok = 1'b0;
      in_value = 8'($urandom);
      in_valid = 1'($urandom);
      @(negedge clk);
      edges++;
    end
    in_valid = 1'b0;
    chk("latency", edges, 9);
    chk("busy_ready", busy_ok, 1'b1);
    chk("ready_after", rdy1, 1'b1);
    chk("done_all", {done2, done3}, 2'b11);
    check_all(int'(v));
    @(negedge clk);
    chk("done_pulse", done1, 1'b0);
  endtask

  initial begin
    int pulses;
    tbl[0] = '{8'd21,  {BLANK, CODES[2], CODES[1]},    {CODES[2], CODES[1]}, 1'b0};
    tbl[1] = '{8'd0,   {BLANK, BLANK, CODES[0]},       {BLANK, CODES[0]},    1'b0};
    tbl[2] = '{8'd100, {CODES[1], CODES[0], CODES[0]}, {DASH, DASH},         1'b1};
    tbl[3] = '{8'd255, {CODES[2], CODES[5], CODES[5]}, {DASH, DASH},         1'b1};
    tbl[4] = '{8'd99,  {BLANK, CODES[9], CODES[9]},    {CODES[9], CODES[9]}, 1'b0};
    tbl[5] = '{8'd100, {CODES[1], CODES[0], CODES[0]}, {DASH, DASH},         1'b1};
    tbl[6] = '{8'd5,   {BLANK, BLANK, CODES[5]},       {BLANK, CODES[5]},    1'b0};
    tbl[7] = '{8'd7,   {BLANK, BLANK, CODES[7]},       {BLANK, CODES[7]},    1'b0};

    resetn   = 1'b0;
    in_valid = 1'b0;
    in_value = 8'd0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      convert(tbl[i].val);
      chk("tbl_seg_d3", seg1, tbl[i].exp_seg3);
      chk("tbl_seg_d2", seg2, tbl[i].exp_seg2);
      chk("tbl_ovf_d2", ovf2, tbl[i].exp_ovf2);
    end

    // Reset during SHIFT aborts the conversion
    in_value = 8'd42;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check_reset("midrst");
    resetn = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done1 === 1'b1) pulses++;
    end
    chk("midrst_no_done", pulses, 0);
    convert(8'd13);

    // Back-to-back with in_valid held high and in_value ramping every cycle
    pulses = 0;
    for (int c = 0; c < 45; c++) begin
      in_value = 8'(30 + c);
      in_valid = 1'b1;
      @(negedge clk);
      if (done1 === 1'b1) begin
        chk("b2b_time", c, 9 + 10 * pulses);
        check_all(30 + 10 * pulses);
        pulses++;
      end
    end
    in_valid = 1'b0;
    chk("b2b_pulses", pulses, 4);
    repeat (12) @(negedge clk);

    for (int n = 0; n < 20; n++) begin
      convert(8'($urandom_range(0, 255)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
